// File: rtl/llc_bus_if.sv
// llc_bus_if: queues LLC bus operations (READ/WRITE/INVALIDATE/RWIM), issues them
// one at a time on the system bus with a req/gnt handshake, collects the snoop
// result (with timeout) and returns the completion to the cache.
// Optional macro LLC_BUS_STATS_EN adds saturating per-op and timeout counters.
module llc_bus_if #(
  parameter int ADDR_SIZE     = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int SNOOP_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [ADDR_SIZE-1:0] req_addr,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic [2:0]           bus_op,
  output logic [ADDR_SIZE-1:0] bus_addr,
  input  logic                 snoop_valid,
  input  logic [1:0]           snoop_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2:0]           resp_op,
  output logic [ADDR_SIZE-1:0] resp_addr,
  output logic [1:0]           resp_result,
  output logic                 resp_timeout,
  output logic                 busy
`ifdef LLC_BUS_STATS_EN
  ,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_writes,
  output logic [31:0]          stat_invals,
  output logic [31:0]          stat_rwims,
  output logic [31:0]          stat_timeouts
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(SNOOP_TIMEOUT) + 1;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INVAL = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, SNOOP, RESP} state_t;

  // Reserved snoop code 3 is treated as the most conservative answer (HITM).
  function automatic logic [1:0] map_snoop(input logic [1:0] r);
    return (r == 2'd3) ? 2'd2 : r;
  endfunction

  state_t                 state_q, state_d;
  logic [2:0]             fifo_op   [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0]   fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   rdy_q;
  logic                   push, pop, op_ok;
  logic [2:0]             op_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [1:0]             res_q, cap_res;
  logic                   to_q, cap_to, cap_en;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   cnt_clr, cnt_inc;

  // rdy_q holds req_ready low through reset and for the edge that ends it.
  assign req_ready = rdy_q && (count != CNT_W'(FIFO_DEPTH));
  assign op_ok     = (req_op >= OP_READ) && (req_op <= OP_RWIM);
  assign push      = req_valid && req_ready && op_ok;

  // Queue control: pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= req_op;
      fifo_addr[wr_ptr] <= req_addr;
    end
  end

  // Next-state logic plus pop, snoop-counter and result-capture strobes.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    cap_en  = 1'b0;
    cap_res = 2'd0;
    cap_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_gnt) begin
          if (op_q == OP_READ || op_q == OP_RWIM) begin
            cnt_clr = 1'b1;
            state_d = SNOOP;
          end else begin
            cap_en  = 1'b1;
            state_d = RESP;
          end
        end
      end
      SNOOP: begin
        if (snoop_valid) begin
          cap_en  = 1'b1;
          cap_res = map_snoop(snoop_result);
          state_d = RESP;
        end else if (tmo_cnt == TMO_W'(SNOOP_TIMEOUT - 1)) begin
          cap_en  = 1'b1;
          cap_to  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and snoop-timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_clr)      tmo_cnt <= '0;
      else if (cnt_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Operation and result registers: data only, loaded on pop and on capture.
  always_ff @(posedge clk) begin
    if (pop) begin
      op_q   <= fifo_op[rd_ptr];
      addr_q <= fifo_addr[rd_ptr];
    end
    if (cap_en) begin
      res_q <= cap_res;
      to_q  <= cap_to;
    end
  end

  // Outputs are gated by state so they read zero whenever not meaningful.
  assign bus_req      = (state_q == ISSUE);
  assign bus_op       = bus_req ? op_q : 3'd0;
  assign bus_addr     = bus_req ? addr_q : '0;
  assign resp_valid   = (state_q == RESP);
  assign resp_op      = resp_valid ? op_q : 3'd0;
  assign resp_addr    = resp_valid ? addr_q : '0;
  assign resp_result  = resp_valid ? res_q : 2'd0;
  assign resp_timeout = resp_valid ? to_q : 1'b0;
  assign busy         = (state_q != IDLE) || (count != '0);

`ifdef LLC_BUS_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Completion statistics, counted on the response handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_reads    <= '0;
      stat_writes   <= '0;
      stat_invals   <= '0;
      stat_rwims    <= '0;
      stat_timeouts <= '0;
    end else if (resp_valid && resp_ready) begin
      case (op_q)
        OP_READ:  stat_reads  <= sat_inc(stat_reads);
        OP_WRITE: stat_writes <= sat_inc(stat_writes);
        OP_INVAL: stat_invals <= sat_inc(stat_invals);
        OP_RWIM:  stat_rwims  <= sat_inc(stat_rwims);
        default:  ;
      endcase
      if (to_q) stat_timeouts <= sat_inc(stat_timeouts);
    end
  end
`endif

endmodule

// File: tb/tb_llc_bus_if.sv
// Testbench for llc_bus_if: cycle table for the basic READ/WRITE/drop flows,
// then hand sequences for snoop timeout, FIFO full, reset abort and statistics.
module tb_llc_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic        snoop_valid = 1'b0;
  logic [1:0]  snoop_result = 2'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [2:0]  resp_op;
  logic [31:0] resp_addr;
  logic [1:0]  resp_result;
  logic        resp_timeout;
  logic        busy;
`ifdef LLC_BUS_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_invals, stat_rwims, stat_timeouts;
`endif

  int checks = 0;
  int failures = 0;

  llc_bus_if #(.ADDR_SIZE(32), .FIFO_DEPTH(4), .SNOOP_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_op(bus_op), .bus_addr(bus_addr),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
    .resp_addr(resp_addr), .resp_result(resp_result), .resp_timeout(resp_timeout),
    .busy(busy)
`ifdef LLC_BUS_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_invals(stat_invals),
    .stat_rwims(stat_rwims), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        gnt;
    logic        sv;
    logic [1:0]  sr;
    logic        rr;
    logic        e_rdy;
    logic        e_breq;
    logic [2:0]  e_bop;
    logic [31:0] e_baddr;
    logic        e_rv;
    logic [2:0]  e_rop;
    logic [31:0] e_raddr;
    logic [1:0]  e_res;
    logic        e_to;
    logic        e_busy;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Enqueue one op, let it reach SNOOP, optionally strobe snoop on SNOOP cycle scyc.
  task automatic run_snoop(input logic [2:0] op, input logic [31:0] addr, input int scyc,
                           input logic [1:0] sres, input int exp_n, input logic [1:0] exp_res,
                           input logic exp_to, input string nm);
    int n;
    bus_gnt = 1'b1; req_valid = 1'b1; req_op = op; req_addr = addr;
    step();
    req_valid = 1'b0;
    step();
    step();
    n = 0;
    do begin
      if (n + 1 == scyc) begin
        snoop_valid = 1'b1; snoop_result = sres;
      end
      step();
      snoop_valid = 1'b0;
      n++;
    end while (!resp_valid && n < 20);
    chk({nm, ".snoop_cycles"}, n, exp_n);
    chk({nm, ".resp_valid"}, resp_valid, 1'b1);
    chk({nm, ".resp_result"}, resp_result, exp_res);
    chk({nm, ".resp_timeout"}, resp_timeout, exp_to);
    chk({nm, ".resp_op"}, resp_op, op);
    chk({nm, ".resp_addr"}, resp_addr, addr);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({nm, ".released"}, resp_valid, 1'b0);
  endtask

  task automatic run_write(input logic [31:0] addr, input string nm);
    bus_gnt = 1'b1; req_valid = 1'b1; req_op = 3'd2; req_addr = addr;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk({nm, ".resp_valid"}, resp_valid, 1'b1);
    chk({nm, ".resp_result"}, resp_result, 2'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] addrs [5];
    int guard;
    logic saw_resp;

    //         vld op   addr        gnt sv sr   rr | rdy breq bop  baddr       rv rop  raddr       res  to busy
    vecs[0]  = '{1, 3'd1, 32'h1000, 1, 0, 2'd0, 0,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 1};
    vecs[1]  = '{0, 3'd0, 32'h0,    1, 0, 2'd0, 0,  1, 1, 3'd1, 32'h1000, 0, 3'd0, 32'h0,    2'd0, 0, 1};
    vecs[2]  = '{0, 3'd0, 32'h0,    1, 1, 2'd1, 0,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 1};
    vecs[3]  = '{0, 3'd0, 32'h0,    1, 1, 2'd1, 0,  1, 0, 3'd0, 32'h0,    1, 3'd1, 32'h1000, 2'd1, 0, 1};
    vecs[4]  = '{0, 3'd0, 32'h0,    1, 0, 2'd0, 1,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 0};
    vecs[5]  = '{1, 3'd2, 32'h2000, 0, 0, 2'd0, 0,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 1};
    vecs[6]  = '{0, 3'd0, 32'h0,    0, 0, 2'd0, 0,  1, 1, 3'd2, 32'h2000, 0, 3'd0, 32'h0,    2'd0, 0, 1};
    vecs[7]  = '{0, 3'd0, 32'h0,    0, 0, 2'd0, 0,  1, 1, 3'd2, 32'h2000, 0, 3'd0, 32'h0,    2'd0, 0, 1};
    vecs[8]  = '{0, 3'd0, 32'h0,    0, 0, 2'd0, 0,  1, 1, 3'd2, 32'h2000, 0, 3'd0, 32'h0,    2'd0, 0, 1};
    vecs[9]  = '{0, 3'd0, 32'h0,    1, 0, 2'd0, 0,  1, 0, 3'd0, 32'h0,    1, 3'd2, 32'h2000, 2'd0, 0, 1};
    vecs[10] = '{0, 3'd0, 32'h0,    0, 0, 2'd0, 0,  1, 0, 3'd0, 32'h0,    1, 3'd2, 32'h2000, 2'd0, 0, 1};
    vecs[11] = '{0, 3'd0, 32'h0,    0, 0, 2'd0, 1,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 0};
    vecs[12] = '{1, 3'd0, 32'h3000, 0, 0, 2'd0, 0,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 0};
    vecs[13] = '{1, 3'd7, 32'h3004, 0, 0, 2'd0, 0,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 0};
    vecs[14] = '{0, 3'd0, 32'h0,    0, 0, 2'd0, 0,  1, 0, 3'd0, 32'h0,    0, 3'd0, 32'h0,    2'd0, 0, 0};

    // Reset state
    repeat (2) step();
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.bus_req", bus_req, 1'b0);
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    rst = 1'b1;
    step();
    chk("rst.req_ready_after", req_ready, 1'b1);

    // Table-driven flows
    for (int i = 0; i < 15; i++) begin
      req_valid = vecs[i].vld; req_op = vecs[i].op; req_addr = vecs[i].addr;
      bus_gnt = vecs[i].gnt; snoop_valid = vecs[i].sv; snoop_result = vecs[i].sr;
      resp_ready = vecs[i].rr;
      step();
      chk($sformatf("vec%0d.req_ready", i), req_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d.bus_req", i), bus_req, vecs[i].e_breq);
      chk($sformatf("vec%0d.bus_op", i), bus_op, vecs[i].e_bop);
      chk($sformatf("vec%0d.bus_addr", i), bus_addr, vecs[i].e_baddr);
      chk($sformatf("vec%0d.resp_valid", i), resp_valid, vecs[i].e_rv);
      chk($sformatf("vec%0d.resp_op", i), resp_op, vecs[i].e_rop);
      chk($sformatf("vec%0d.resp_addr", i), resp_addr, vecs[i].e_raddr);
      chk($sformatf("vec%0d.resp_result", i), resp_result, vecs[i].e_res);
      chk($sformatf("vec%0d.resp_timeout", i), resp_timeout, vecs[i].e_to);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
    end
    req_valid = 1'b0; snoop_valid = 1'b0; resp_ready = 1'b0;

    // Snoop timeout, HITM on the last SNOOP cycle, reserved code on first cycle
    run_snoop(3'd4, 32'hFFFF_8000, 0, 2'd0, 8, 2'd0, 1'b1, "rwim_tmo");
    run_snoop(3'd4, 32'hFFFF_8000, 8, 2'd2, 8, 2'd2, 1'b0, "rwim_hitm8");
    run_snoop(3'd1, 32'h0000_5000, 1, 2'd3, 1, 2'd2, 1'b0, "read_rsvd");

    // FIFO full with grant withheld, then in-order drain
    bus_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addrs[i] = 32'h4000 + 32'h100 * i;
      req_valid = 1'b1; req_op = 3'd1; req_addr = addrs[i];
      guard = 0;
      while (!req_ready && guard < 10) begin
        step();
        guard++;
      end
      chk($sformatf("full.accept%0d", i), req_ready, 1'b1);
      step();
    end
    chk("full.req_ready", req_ready, 1'b0);
    req_addr = 32'h4500;
    step();
    step();
    chk("full.req_ready_hold", req_ready, 1'b0);
    chk("full.bus_addr", bus_addr, addrs[0]);
    req_valid = 1'b0;
    bus_gnt = 1'b1; snoop_valid = 1'b1; snoop_result = 2'd1;
    for (int i = 0; i < 5; i++) begin
      guard = 0;
      while (!resp_valid && guard < 20) begin
        step();
        guard++;
      end
      chk($sformatf("drain%0d.resp_addr", i), resp_addr, addrs[i]);
      chk($sformatf("drain%0d.resp_result", i), resp_result, 2'd1);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
    end
    step();
    chk("drain.busy_after", busy, 1'b0);
    snoop_valid = 1'b0;

    // Reset during SNOOP with two entries queued
    bus_gnt = 1'b1; req_valid = 1'b1; req_op = 3'd1;
    req_addr = 32'h6000; step();
    req_addr = 32'h6040; step();
    req_addr = 32'h6080; step();
    req_valid = 1'b0;
    chk("abort.busy_before", busy, 1'b1);
    rst = 1'b0;
    step();
    chk("abort.req_ready", req_ready, 1'b0);
    chk("abort.bus_req", bus_req, 1'b0);
    chk("abort.bus_op", bus_op, 3'd0);
    chk("abort.bus_addr", bus_addr, 32'h0);
    chk("abort.resp_valid", resp_valid, 1'b0);
    chk("abort.resp_op", resp_op, 3'd0);
    chk("abort.resp_addr", resp_addr, 32'h0);
    chk("abort.resp_result", resp_result, 2'd0);
    chk("abort.resp_timeout", resp_timeout, 1'b0);
    chk("abort.busy", busy, 1'b0);
    rst = 1'b1;
    resp_ready = 1'b1; snoop_valid = 1'b1;
    saw_resp = 1'b0;
    repeat (12) begin
      step();
      if (resp_valid) saw_resp = 1'b1;
    end
    chk("abort.no_resp", saw_resp, 1'b0);
    chk("abort.busy_after", busy, 1'b0);
    resp_ready = 1'b0; snoop_valid = 1'b0;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h7000;
    step();
    req_valid = 1'b0;
    step();
    chk("abort.drop_busy", busy, 1'b0);

`ifdef LLC_BUS_STATS_EN
    chk("stats.reset_reads", stat_reads, 32'd0);
    run_snoop(3'd1, 32'h8000, 1, 2'd1, 1, 2'd1, 1'b0, "st_read0");
    run_snoop(3'd1, 32'h8040, 1, 2'd0, 1, 2'd0, 1'b0, "st_read1");
    run_write(32'h8080, "st_write");
    run_snoop(3'd4, 32'h80C0, 0, 2'd0, 8, 2'd0, 1'b1, "st_rwim");
    chk("stats.reads", stat_reads, 32'd2);
    chk("stats.writes", stat_writes, 32'd1);
    chk("stats.invals", stat_invals, 32'd0);
    chk("stats.rwims", stat_rwims, 32'd1);
    chk("stats.timeouts", stat_timeouts, 32'd1);
`else
    run_write(32'h8080, "write_end");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/llc_bus_if.md
Name: llc_bus_if

Overview:
- Downstream stage of the LLC cache array. It takes the bus operations the cache generates on misses, writebacks and invalidates, and queues them in a small FIFO.
- It drives them onto the shared system bus one at a time with a request/grant handshake, and collects the snoop result from other caches (NOHIT/HIT/HITM).
- It returns the completed operation and its result to the cache. The cache uses the result to choose the MESI fill state: HIT gives S, NOHIT gives E.

Parameters:
- ADDR_SIZE, 32, request/bus address width.
- FIFO_DEPTH, 4, pending-request queue entries (power of 2, ≥2).
- SNOOP_TIMEOUT, 8, cycles waited for snoop_valid before defaulting to NOHIT (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  cache presents a bus operation.
- req_ready  out  1  queue can accept; equals !full.
- req_op  in  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM.
- req_addr  in  ADDR_SIZE  line address.
- bus_req  out  1  bus request.
- bus_gnt  in  1  bus grant.
- bus_op  out  3  operation on bus.
- bus_addr  out  ADDR_SIZE  address on bus.
- snoop_valid  in  1  snoop result strobe.
- snoop_result  in  2  0=NOHIT, 1=HIT, 2=HITM, 3=reserved.
- resp_valid  out  1  completion to cache.
- resp_ready  in  1  cache accepts completion.
- resp_op  out  3  completed op.
- resp_addr  out  ADDR_SIZE  completed address.
- resp_result  out  2  final snoop result.
- resp_timeout  out  1  result came from timeout.
- busy  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
Interface and reset:
- Single clock clk. rst is synchronous, active-low.
- While rst=0 at a rising edge: FIFO empty, FSM=IDLE, all outputs 0 except req_ready=0 during reset and 1 the first cycle after.
- Reset mid-operation aborts the transaction and discards queued entries. No response is produced for them.

Enqueue:
- Enqueue occurs on a clk edge with req_valid && req_ready.
- req_op of 0, 5, 6 or 7 is accepted but not enqueued (silent drop).
- req_ready is derived from the registered count, so a push and a pop in the same cycle with a full FIFO do not accept the push.
- Simultaneous push and pop when not full: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states IDLE, ISSUE, SNOOP, RESP:
- IDLE: if FIFO non-empty, pop head into the op/addr registers and go to ISSUE.
- ISSUE: bus_req=1, bus_op/bus_addr driven from the registers. On bus_gnt=1:
  - READ or RWIM goes to SNOOP; the timeout counter clears.
  - WRITE or INVALIDATE goes to RESP with result NOHIT and resp_timeout=0.
- SNOOP: bus_req=0.
  - On snoop_valid=1: capture snoop_result, mapping 3 to HITM, then go to RESP with resp_timeout=0.
  - Otherwise the counter increments. On the cycle where counter==SNOOP_TIMEOUT-1 without snoop_valid, go to RESP with NOHIT and resp_timeout=1.
  - snoop_valid in that final cycle wins; it is not a timeout.
- RESP: resp_valid=1 with resp_op/resp_addr/resp_result/resp_timeout stable. On resp_ready=1, go to IDLE.
- snoop_valid outside SNOOP is ignored. bus_gnt outside ISSUE is ignored.

Latency:
- Minimum from accept edge to resp_valid is 3 cycles for WRITE/INVALIDATE with bus_gnt already high: IDLE, then ISSUE, then RESP.
- For READ with snoop in the first SNOOP cycle, it is 4 cycles.
- Throughput is at most one operation per 3 cycles. Enqueue continues while the FSM is busy.

Optional Feature:
- Macro LLC_BUS_STATS_EN.
- When defined: adds outputs stat_reads, stat_writes, stat_invals, stat_rwims, stat_timeouts, each 32 bits.
  - The first four increment on RESP handshake completion, by op.
  - stat_timeouts increments on each timeout completion.
  - All are cleared by rst and saturate at all-ones.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- READ 0x0000_1000, bus_gnt held 1, snoop_valid with HIT on first SNOOP cycle → bus_req 1 cycle, resp_valid at cycle 4, resp_result=1, resp_timeout=0.
- WRITE 0x0000_2000, bus_gnt delayed 3 cycles → bus_req held 3 cycles with stable bus_addr, no SNOOP state, resp_result=0.
- RWIM 0xFFFF_8000 with no snoop_valid, SNOOP_TIMEOUT=8 → resp after exactly 8 SNOOP cycles, resp_result=0, resp_timeout=1. Repeat with snoop_valid HITM on the 8th cycle → resp_result=2, resp_timeout=0.
- Push 5 READs back-to-back with bus_gnt=0, FIFO_DEPTH=4 → 4 accepted (the head is popped into the FSM, so the 5th is accepted one cycle later), req_ready=0 while full. Release grant → responses come out in order of address.
- Assert rst=0 during SNOOP with 2 entries queued → next cycle all outputs 0, busy=0, no resp_valid afterwards. req_op=0 enqueued → dropped, busy stays 0.
- With LLC_BUS_STATS_EN: 2 READ, 1 WRITE, 1 timed-out RWIM → stat_reads=2, stat_writes=1, stat_rwims=1, stat_timeouts=1.
